rng_arbiter: RTL

- Sequencer and round-robin arbiter in front of the simplerng block.
- Shares one RNG word stream between NUM_REQ requesters, e.g. the CPU bus slot and the BRLWE error sampler.
- Issues reseed writes and discards WARMUP words after every reset or reseed, so no requester receives seed-correlated output.
- Sits between the requesters and the RNG instance. It drives the RNG enable/we/re/di signals and consumes the RNG do/wait signals.

---
 rtl/rng_pkg.sv | 11 +
 rtl/rng_arbiter_if.sv | 14 +
 rtl/rng_arbiter_rr_pick.sv | 22 ++
 rtl/rng_arbiter.sv | 74 +++++++
 4 files changed

// File: rtl/rng_pkg.sv
// rng_pkg: shared types and helpers for the RNG sequencer/arbiter
package rng_pkg;
  typedef enum logic [1:0] {WARM = 2'd0, READY = 2'd1, SEED = 2'd2} state_t;
  localparam int MAX_BITS = 32;
  localparam int NUM_REQ_DEF = 2;
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int PTR_W = ptr_w(NUM_REQ_DEF);
  typedef logic [MAX_BITS-1:0] word_t;
endpackage

// File: rtl/rng_arbiter_if.sv
// rng_arbiter_if: requester-side request/response and reseed bus
interface rng_arbiter_if #(
  parameter int NUM_BITS = 32,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_BITS-1:0] rsp_data;
  logic seed_we;
  logic [NUM_BITS-1:0] seed_data;
  logic seed_busy;
  modport master (output req_valid, seed_we, seed_data, input rsp_valid, rsp_data, seed_busy);
  modport slave (input req_valid, seed_we, seed_data, output rsp_valid, rsp_data, seed_busy);
endinterface

// File: rtl/rng_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first eligible index at or after ptr
module rr_pick #(
  parameter int N = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic          gv,
  output logic [PW-1:0] gi
);
  logic [N-1:0] rot;
  logic [PW:0] off, sum;
  always_comb begin
    rot = N'({elig, elig} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) off = (PW + 1)'(k);
    sum = off + {1'b0, ptr};
    gi = (sum >= (PW + 1)'(N)) ? PW'(sum - (PW + 1)'(N)) : sum[PW-1:0];
    gv = |elig;
  end
endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: warm-up/reseed sequencer and round-robin arbiter in front of simplerng
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int NUM_REQ = 2,
  parameter int WARMUP = 4
) (
  input  logic                clk,
  input  logic                reset,
  rng_arbiter_if.slave        bus,
  output logic                rng_enable,
  output logic                rng_we,
  output logic                rng_re,
  output logic [NUM_BITS-1:0] rng_di,
  input  logic [NUM_BITS-1:0] rng_do,
  input  logic                rng_wait,
  output logic [31:0]         words_cnt
);
  localparam int PW = ptr_w(NUM_REQ);
  state_t state, state_n;
  logic [7:0] warm_cnt, warm_n;
  logic [PW-1:0] rr_ptr, gi;
  logic gv, grant, seed_ok, last, warm_step, re_int;
  logic [NUM_REQ-1:0] rsp_q;
  logic [NUM_BITS-1:0] data_q, di_q;
  logic [31:0] words_q;
  // a requester just served is masked for one cycle so it can drop its request
  rr_pick #(.N(NUM_REQ), .PW(PW)) pick (
    .elig(bus.req_valid & ~rsp_q),
    .ptr(rr_ptr),
    .gv(gv),
    .gi(gi)
  );
  always_comb begin
    seed_ok = bus.seed_we & ((state == READY) | ((state == WARM) & (warm_cnt == 8'd0)));
    grant = (state == READY) & gv & ~rng_wait & ~bus.seed_we;
    last = warm_cnt == 8'(WARMUP - 1);
    warm_step = (state == WARM) & ~seed_ok & ~rng_wait;
    re_int = grant | warm_step;
    state_n = seed_ok ? SEED : (state == SEED) ? WARM : (warm_step & last) ? READY : state;
    warm_n = warm_step ? (last ? 8'd0 : warm_cnt + 8'd1) : (state == SEED) ? 8'd0 : warm_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WARM;
      warm_cnt <= '0;
      rr_ptr <= '0;
      rsp_q <= '0;
      data_q <= '0;
      di_q <= '0;
      words_q <= '0;
    end else begin
      state <= state_n;
      warm_cnt <= warm_n;
      rsp_q <= grant ? NUM_REQ'(1) << gi : '0;
      if (grant) begin
        data_q <= rng_do;
        rr_ptr <= (gi == PW'(NUM_REQ - 1)) ? '0 : gi + 1'b1;
        words_q <= words_q + 32'd1;
      end
      if (seed_ok) di_q <= bus.seed_data;
    end
  end
  // outputs are forced to their reset values for as long as reset is held
  assign rng_enable = ~reset;
  assign rng_we = ~reset & (state == SEED);
  assign rng_re = ~reset & re_int;
  assign rng_di = reset ? '0 : di_q;
  assign words_cnt = reset ? '0 : words_q;
  assign bus.rsp_valid = reset ? '0 : rsp_q;
  assign bus.rsp_data = reset ? '0 : data_q;
  assign bus.seed_busy = reset | (state != READY);
endmodule
